inta_sequencer: RTL and testbench

INTA_SEQUENCER -- requirements
Module: inta_sequencer

---
 rtl/pic_pkg.sv | 23 ++
 rtl/inta_sequencer_if.sv | 30 +++
 rtl/inta_sequencer_core.sv | 113 +++++++++++
 rtl/is_priority_finder.sv | 23 ++
 rtl/inta_sequencer.sv | 46 ++++
 tb/tb_inta_sequencer.sv | 163 ++++++++++++++++
 6 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt acknowledge sequencer.
// Holds the FSM encoding, the EOI command codes and the spurious id.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK1 = 2'd2,
        ACK2 = 2'd3
    } state_t;

    localparam logic [1:0] EOI_NS  = 2'b00;
    localparam logic [1:0] EOI_SP  = 2'b01;
    localparam logic [1:0] EOI_RNS = 2'b10;
    localparam logic [1:0] EOI_RSP = 2'b11;

    localparam logic [2:0] SPURIOUS_ID = 3'd7;

    function automatic logic [7:0] onehot8(input logic [2:0] i);
        return 8'd1 << i;
    endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// Signal bundle between the resolver/CPU side and the acknowledge core.
// slave is the sequencer's view; master is the driving environment's view.
interface inta_sequencer_if #(parameter int VEC_W = 5);
    logic             INTFLAG;
    logic [2:0]       PriorityID;
    logic             INTA_n;
    logic             AEOI;
    logic [VEC_W-1:0] Vector_base;
    logic             EOI_cmd;
    logic [1:0]       EOI_type;
    logic [2:0]       EOI_level;
    logic             INT;
    logic [7:0]       IS_status;
    logic [2:0]       last_serviced;
    logic [7:0]       IRQ_clear;
    logic [7:0]       Data_out;
    logic             Data_en;

    modport master (
        output INTFLAG, PriorityID, INTA_n, AEOI, Vector_base,
        output EOI_cmd, EOI_type, EOI_level,
        input  INT, IS_status, last_serviced, IRQ_clear, Data_out, Data_en
    );

    modport slave (
        input  INTFLAG, PriorityID, INTA_n, AEOI, Vector_base,
        input  EOI_cmd, EOI_type, EOI_level,
        output INT, IS_status, last_serviced, IRQ_clear, Data_out, Data_en
    );
endinterface

// File: rtl/inta_sequencer_core.sv
// INTA handshake FSM, in-service register and EOI handling.
// All outputs are registered onto the slave side of the bundle.
module inta_sequencer_core
    import pic_pkg::*;
(
    input logic               clk,
    input logic               reset,
    inta_sequencer_if.slave   bus
);
    state_t     state, state_nxt;
    logic       inta_prev;
    logic       fall, rise;
    logic [2:0] id_q, id_nxt;
    logic       spur_q, spur_nxt;
    logic [7:0] set_mask, aeoi_mask, eoi_mask;
    logic       rot_load;
    logic [2:0] rot_level;
    logic [2:0] top_id;
    logic       top_valid;

    assign fall = inta_prev & ~bus.INTA_n;
    assign rise = ~inta_prev & bus.INTA_n;

    is_priority_finder u_finder (
        .vec   (bus.IS_status),
        .base  (bus.last_serviced),
        .id    (top_id),
        .valid (top_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = id_q;
        spur_nxt  = spur_q;
        set_mask  = '0;
        aeoi_mask = '0;
        unique case (state)
            IDLE: if (bus.INTFLAG) state_nxt = PEND;
            PEND: begin
                if (fall) begin
                    state_nxt = ACK1;
                    spur_nxt  = ~bus.INTFLAG;
                    id_nxt    = bus.INTFLAG ? bus.PriorityID : SPURIOUS_ID;
                    if (bus.INTFLAG) set_mask = onehot8(bus.PriorityID);
                end else if (!bus.INTFLAG) begin
                    state_nxt = IDLE;
                end
            end
            ACK1: if (fall) state_nxt = ACK2;
            ACK2: begin
                if (rise) begin
                    state_nxt = IDLE;
                    if (bus.AEOI && !spur_q) aeoi_mask = onehot8(id_q);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        eoi_mask  = '0;
        rot_load  = 1'b0;
        rot_level = bus.last_serviced;
        if (bus.EOI_cmd) begin
            unique case (bus.EOI_type)
                EOI_NS, EOI_RNS: begin
                    if (top_valid) begin
                        eoi_mask  = onehot8(top_id);
                        rot_level = top_id;
                        rot_load  = (bus.EOI_type == EOI_RNS);
                    end
                end
                default: begin
                    eoi_mask  = onehot8(bus.EOI_level);
                    rot_level = bus.EOI_level;
                    rot_load  = (bus.EOI_type == EOI_RSP);
                end
            endcase
        end
    end

    // EOI/AEOI clears act on the old IS value; an INTA set is applied last.
    always_ff @(posedge clk) begin
        if (reset) begin
            inta_prev         <= 1'b1;
            id_q              <= '0;
            spur_q            <= 1'b0;
            bus.INT           <= 1'b0;
            bus.IS_status     <= '0;
            bus.last_serviced <= 3'd7;
            bus.IRQ_clear     <= '0;
            bus.Data_out      <= '0;
            bus.Data_en       <= 1'b0;
        end else begin
            inta_prev     <= bus.INTA_n;
            id_q          <= id_nxt;
            spur_q        <= spur_nxt;
            bus.INT       <= (state_nxt == PEND);
            bus.IS_status <= (bus.IS_status & ~eoi_mask & ~aeoi_mask)
                             | set_mask;
            if (rot_load) bus.last_serviced <= rot_level;
            bus.IRQ_clear <= set_mask;
            bus.Data_en   <= (state_nxt == ACK2);
            bus.Data_out  <= (state_nxt == ACK2)
                             ? 8'({bus.Vector_base, id_nxt}) : 8'h00;
        end
    end
endmodule

// File: rtl/is_priority_finder.sv
// Finds the first set bit of vec scanning base+1, base+2, ... modulo 8.
// Used to pick the in-service level a non-specific EOI clears.
module is_priority_finder (
    input  logic [7:0] vec,
    input  logic [2:0] base,
    output logic [2:0] id,
    output logic       valid
);
    always_comb begin
        logic [2:0] idx;
        id    = '0;
        valid = 1'b0;
        idx   = '0;
        // Scan lowest priority first so the highest-priority hit wins.
        for (int k = 8; k >= 1; k--) begin
            idx = base + 3'(k);
            if (vec[idx]) begin
                id    = idx;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/inta_sequencer.sv
// Top level: flat pin-level ports mapped onto the sequencer bundle.
// The acknowledge logic itself lives in inta_sequencer_core.
module inta_sequencer #(
    parameter int VEC_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             INTFLAG,
    input  logic [2:0]       PriorityID,
    input  logic             INTA_n,
    input  logic             AEOI,
    input  logic [VEC_W-1:0] Vector_base,
    input  logic             EOI_cmd,
    input  logic [1:0]       EOI_type,
    input  logic [2:0]       EOI_level,
    output logic             INT,
    output logic [7:0]       IS_status,
    output logic [2:0]       last_serviced,
    output logic [7:0]       IRQ_clear,
    output logic [7:0]       Data_out,
    output logic             Data_en
);
    inta_sequencer_if #(.VEC_W(VEC_W)) bus ();

    assign bus.INTFLAG     = INTFLAG;
    assign bus.PriorityID  = PriorityID;
    assign bus.INTA_n      = INTA_n;
    assign bus.AEOI        = AEOI;
    assign bus.Vector_base = Vector_base;
    assign bus.EOI_cmd     = EOI_cmd;
    assign bus.EOI_type    = EOI_type;
    assign bus.EOI_level   = EOI_level;

    assign INT           = bus.INT;
    assign IS_status     = bus.IS_status;
    assign last_serviced = bus.last_serviced;
    assign IRQ_clear     = bus.IRQ_clear;
    assign Data_out      = bus.Data_out;
    assign Data_en       = bus.Data_en;

    inta_sequencer_core u_core (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );
endmodule

// File: tb/tb_inta_sequencer.sv
// Cycle-by-cycle directed vectors for inta_sequencer.
// Each record drives one clock of inputs and lists the registered outputs.
module tb_inta_sequencer;
    import pic_pkg::*;

    typedef struct {
        string      name;
        logic       rst;
        logic       flag;
        logic [2:0] pid;
        logic       inta;
        logic       aeoi;
        logic       eoi;
        logic [1:0] etype;
        logic [2:0] elvl;
        logic       int_e;
        logic [7:0] is_e;
        logic [2:0] ls_e;
        logic [7:0] clr_e;
        logic [7:0] dout_e;
        logic       den_e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    inta_sequencer_if #(.VEC_W(5)) bus ();

    inta_sequencer #(.VEC_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .INTFLAG       (bus.INTFLAG),
        .PriorityID    (bus.PriorityID),
        .INTA_n        (bus.INTA_n),
        .AEOI          (bus.AEOI),
        .Vector_base   (bus.Vector_base),
        .EOI_cmd       (bus.EOI_cmd),
        .EOI_type      (bus.EOI_type),
        .EOI_level     (bus.EOI_level),
        .INT           (bus.INT),
        .IS_status     (bus.IS_status),
        .last_serviced (bus.last_serviced),
        .IRQ_clear     (bus.IRQ_clear),
        .Data_out      (bus.Data_out),
        .Data_en       (bus.Data_en)
    );

    function automatic vec_t mk(
        input string n, input logic r, input logic f,
        input logic [2:0] p, input logic ia, input logic ae,
        input logic e, input logic [1:0] et, input logic [2:0] el,
        input logic xi, input logic [7:0] xis, input logic [2:0] xls,
        input logic [7:0] xclr, input logic [7:0] xd, input logic xden);
        vec_t v;
        v.name = n; v.rst = r; v.flag = f; v.pid = p; v.inta = ia;
        v.aeoi = ae; v.eoi = e; v.etype = et; v.elvl = el;
        v.int_e = xi; v.is_e = xis; v.ls_e = xls; v.clr_e = xclr;
        v.dout_e = xd; v.den_e = xden;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        logic [28:0] got, want;
        @(negedge clk);
        reset           = v.rst;
        bus.INTFLAG     = v.flag;
        bus.PriorityID  = v.pid;
        bus.INTA_n      = v.inta;
        bus.AEOI        = v.aeoi;
        bus.EOI_cmd     = v.eoi;
        bus.EOI_type    = v.etype;
        bus.EOI_level   = v.elvl;
        @(posedge clk);
        #1;
        got  = {bus.INT, bus.IS_status, bus.last_serviced,
                bus.IRQ_clear, bus.Data_out, bus.Data_en};
        want = {v.int_e, v.is_e, v.ls_e, v.clr_e, v.dout_e, v.den_e};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got INT=%b IS=%h LS=%0d CLR=%h DOUT=%h DEN=%b want INT=%b IS=%h LS=%0d CLR=%h DOUT=%h DEN=%b",
                     v.name, bus.INT, bus.IS_status, bus.last_serviced,
                     bus.IRQ_clear, bus.Data_out, bus.Data_en,
                     v.int_e, v.is_e, v.ls_e, v.clr_e, v.dout_e, v.den_e);
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.INTFLAG     = 1'b0;
        bus.PriorityID  = 3'd0;
        bus.INTA_n      = 1'b1;
        bus.AEOI        = 1'b0;
        bus.Vector_base = 5'h08;
        bus.EOI_cmd     = 1'b0;
        bus.EOI_type    = EOI_NS;
        bus.EOI_level   = 3'd0;

        //            name          rst f pid in ae e type    lvl  INT IS     LS  CLR    DOUT   DEN
        tbl.push_back(mk("reset",      1, 0, 0, 1, 0, 0, EOI_NS, 0,  0, 8'h00, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("idle",       0, 0, 0, 1, 0, 0, EOI_NS, 0,  0, 8'h00, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("pend",       0, 1, 3, 1, 0, 0, EOI_NS, 0,  1, 8'h00, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("pend_hold",  0, 1, 3, 1, 0, 0, EOI_NS, 0,  1, 8'h00, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("ack1",       0, 1, 3, 0, 0, 0, EOI_NS, 0,  0, 8'h08, 7, 8'h08, 8'h00, 0));
        tbl.push_back(mk("clr_pulse",  0, 1, 3, 0, 0, 0, EOI_NS, 0,  0, 8'h08, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("ack1_gap",   0, 1, 3, 1, 0, 0, EOI_NS, 0,  0, 8'h08, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("ack2",       0, 1, 3, 0, 0, 0, EOI_NS, 0,  0, 8'h08, 7, 8'h00, 8'h43, 1));
        tbl.push_back(mk("ack2_hold",  0, 0, 3, 0, 0, 0, EOI_NS, 0,  0, 8'h08, 7, 8'h00, 8'h43, 1));
        tbl.push_back(mk("ack2_rise",  0, 0, 3, 1, 0, 0, EOI_NS, 0,  0, 8'h08, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("eoi_ns",     0, 0, 0, 1, 0, 1, EOI_NS, 0,  0, 8'h00, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("pend_aeoi",  0, 1, 3, 1, 1, 0, EOI_NS, 0,  1, 8'h00, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("ack1_aeoi",  0, 1, 3, 0, 1, 0, EOI_NS, 0,  0, 8'h08, 7, 8'h08, 8'h00, 0));
        tbl.push_back(mk("gap_aeoi",   0, 1, 3, 1, 1, 0, EOI_NS, 0,  0, 8'h08, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("ack2_aeoi",  0, 1, 3, 0, 1, 0, EOI_NS, 0,  0, 8'h08, 7, 8'h00, 8'h43, 1));
        tbl.push_back(mk("aeoi_clear", 0, 0, 3, 1, 1, 0, EOI_NS, 0,  0, 8'h00, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("pend3",      0, 1, 1, 1, 0, 0, EOI_NS, 0,  1, 8'h00, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("pend_drop",  0, 0, 1, 1, 0, 0, EOI_NS, 0,  0, 8'h00, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("pend_spur",  0, 1, 4, 1, 0, 0, EOI_NS, 0,  1, 8'h00, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("spur_ack1",  0, 0, 4, 0, 0, 0, EOI_NS, 0,  0, 8'h00, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("spur_gap",   0, 0, 4, 1, 0, 0, EOI_NS, 0,  0, 8'h00, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("spur_ack2",  0, 0, 4, 0, 0, 0, EOI_NS, 0,  0, 8'h00, 7, 8'h00, 8'h47, 1));
        tbl.push_back(mk("spur_done",  0, 0, 4, 1, 1, 0, EOI_NS, 0,  0, 8'h00, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("pend_l2",    0, 1, 2, 1, 0, 0, EOI_NS, 0,  1, 8'h00, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("ack1_l2",    0, 1, 2, 0, 0, 0, EOI_NS, 0,  0, 8'h04, 7, 8'h04, 8'h00, 0));
        tbl.push_back(mk("gap_l2",     0, 1, 2, 1, 0, 0, EOI_NS, 0,  0, 8'h04, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("ack2_l2",    0, 1, 2, 0, 0, 0, EOI_NS, 0,  0, 8'h04, 7, 8'h00, 8'h42, 1));
        tbl.push_back(mk("done_l2",    0, 0, 2, 1, 0, 0, EOI_NS, 0,  0, 8'h04, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("pend_l5",    0, 1, 5, 1, 0, 0, EOI_NS, 0,  1, 8'h04, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("eoi_vs_set", 0, 1, 5, 0, 0, 1, EOI_SP, 5,  0, 8'h24, 7, 8'h20, 8'h00, 0));
        tbl.push_back(mk("gap_l5",     0, 1, 5, 1, 0, 0, EOI_NS, 0,  0, 8'h24, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("ack2_l5",    0, 1, 5, 0, 0, 0, EOI_NS, 0,  0, 8'h24, 7, 8'h00, 8'h45, 1));
        tbl.push_back(mk("done_l5",    0, 0, 5, 1, 0, 0, EOI_NS, 0,  0, 8'h24, 7, 8'h00, 8'h00, 0));
        tbl.push_back(mk("eoi_rns",    0, 0, 0, 1, 0, 1, EOI_RNS, 0, 0, 8'h20, 2, 8'h00, 8'h00, 0));
        tbl.push_back(mk("eoi_rns2",   0, 0, 0, 1, 0, 1, EOI_RNS, 0, 0, 8'h00, 5, 8'h00, 8'h00, 0));
        tbl.push_back(mk("rns_empty",  0, 0, 0, 1, 0, 1, EOI_RNS, 0, 0, 8'h00, 5, 8'h00, 8'h00, 0));
        tbl.push_back(mk("eoi_rsp",    0, 0, 0, 1, 0, 1, EOI_RSP, 1, 0, 8'h00, 1, 8'h00, 8'h00, 0));
        tbl.push_back(mk("pend_l0",    0, 1, 0, 1, 0, 0, EOI_NS, 0,  1, 8'h00, 1, 8'h00, 8'h00, 0));
        tbl.push_back(mk("ack1_l0",    0, 1, 0, 0, 0, 0, EOI_NS, 0,  0, 8'h01, 1, 8'h01, 8'h00, 0));
        tbl.push_back(mk("eoi_in_ack1",0, 1, 0, 1, 0, 1, EOI_NS, 0,  0, 8'h00, 1, 8'h00, 8'h00, 0));
        tbl.push_back(mk("ack2_l0",    0, 1, 0, 0, 0, 0, EOI_NS, 0,  0, 8'h00, 1, 8'h00, 8'h40, 1));
        tbl.push_back(mk("done_l0",    0, 0, 0, 1, 0, 0, EOI_NS, 0,  0, 8'h00, 1, 8'h00, 8'h00, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Reset asserted while the vector byte is on the bus.
        apply(mk("rp_pend",  0, 1, 6, 1, 0, 0, EOI_NS, 0, 1, 8'h00, 1, 8'h00, 8'h00, 0));
        apply(mk("rp_ack1",  0, 1, 6, 0, 0, 0, EOI_NS, 0, 0, 8'h40, 1, 8'h40, 8'h00, 0));
        apply(mk("rp_gap",   0, 1, 6, 1, 0, 0, EOI_NS, 0, 0, 8'h40, 1, 8'h00, 8'h00, 0));
        apply(mk("rp_ack2",  0, 1, 6, 0, 0, 0, EOI_NS, 0, 0, 8'h40, 1, 8'h00, 8'h46, 1));
        apply(mk("rp_reset", 1, 1, 6, 0, 0, 0, EOI_NS, 0, 0, 8'h00, 7, 8'h00, 8'h00, 0));
        apply(mk("rp_idle",  0, 0, 6, 0, 0, 0, EOI_NS, 0, 0, 8'h00, 7, 8'h00, 8'h00, 0));
        apply(mk("rp_repend",0, 1, 6, 1, 0, 0, EOI_NS, 0, 1, 8'h00, 7, 8'h00, 8'h00, 0));
        apply(mk("rp_drop",  0, 0, 6, 1, 0, 0, EOI_NS, 0, 0, 8'h00, 7, 8'h00, 8'h00, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
